// File: rtl/qif_aer_arbiter_if.sv
// rtl/qif_aer_arbiter_if.sv - spike inputs and AER event bus of the QIF arbiter
interface qif_aer_arbiter_if #(
    parameter int N_CH = 4,
    parameter int TS_W = 8,
    parameter int AW   = 2
);
    logic [N_CH-1:0] spike_in;
    logic            aer_ready;
    logic            clear_ovf;
    logic            aer_valid;
    logic [AW-1:0]   aer_addr;
    logic [TS_W-1:0] aer_time;
    logic [N_CH-1:0] overflow;
    logic [15:0]     evt_cnt;

    // Arbiter side: consumes spikes and ready, produces events and status
    modport slave (
        input  spike_in, aer_ready, clear_ovf,
        output aer_valid, aer_addr, aer_time, overflow, evt_cnt
    );

    // Environment side: neurons, downstream sink and status clear
    modport master (
        output spike_in, aer_ready, clear_ovf,
        input  aer_valid, aer_addr, aer_time, overflow, evt_cnt
    );
endinterface

// File: rtl/qif_aer_arbiter.sv
// rtl/qif_aer_arbiter.sv - round-robin AER arbiter timestamping QIF neuron spikes
module qif_aer_arbiter #(
    parameter int N_CH = 4,
    parameter int TS_W = 8,
    parameter int AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    qif_aer_arbiter_if.slave  bus
);
    logic [TS_W-1:0] ts;
    logic [N_CH-1:0] pending;
    logic [TS_W-1:0] ts_lat [N_CH];
    logic [N_CH-1:0] overflow_q;
    logic            aer_valid_q;
    logic [AW-1:0]   aer_addr_q;
    logic [TS_W-1:0] aer_time_q;
    logic [15:0]     evt_cnt_q;
    logic [AW-1:0]   last_grant;

    logic            slot_free;
    logic            accept;
    logic            grant_valid;
    logic [AW-1:0]   grant_ch;
    logic [AW-1:0]   cand;
    logic [N_CH-1:0] issue;
    logic [N_CH-1:0] ovf_set;

    assign slot_free = ~aer_valid_q | bus.aer_ready;
    assign accept    = aer_valid_q & bus.aer_ready;

    assign bus.aer_valid = aer_valid_q;
    assign bus.aer_addr  = aer_addr_q;
    assign bus.aer_time  = aer_time_q;
    assign bus.overflow  = overflow_q;
    assign bus.evt_cnt   = evt_cnt_q;

    // Round-robin pick: first registered pending channel after last_grant, wrapping
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = AW'((int'(last_grant) + k) % N_CH);
            if (!grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    // One-hot issue vector and lost-spike detection for this cycle
    always_comb begin
        issue = '0;
        if (slot_free && grant_valid) begin
            issue[grant_ch] = 1'b1;
        end
        ovf_set = bus.spike_in & pending & ~issue;
    end

    // Free-running timestamp, wraps naturally at 2^TS_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Spike capture: a spike on an idle or just-issued channel restarts its timestamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ts_lat[i] <= '0;
            end
        end else begin
            pending <= (pending & ~issue) | bus.spike_in;
            for (int i = 0; i < N_CH; i++) begin
                if (bus.spike_in[i] && (!pending[i] || issue[i])) begin
                    ts_lat[i] <= ts;
                end
            end
        end
    end

    // Sticky overflow flags; a new loss beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= (overflow_q & ~{N_CH{bus.clear_ovf}}) | ovf_set;
        end
    end

    // Output slot: load the granted event whenever the slot frees up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aer_valid_q <= 1'b0;
            aer_addr_q  <= '0;
            aer_time_q  <= '0;
            last_grant  <= AW'(N_CH - 1);
        end else if (slot_free) begin
            if (grant_valid) begin
                aer_valid_q <= 1'b1;
                aer_addr_q  <= grant_ch;
                aer_time_q  <= ts_lat[grant_ch];
                last_grant  <= grant_ch;
            end else begin
                aer_valid_q <= 1'b0;
            end
        end
    end

    // Accepted-event counter, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt_q <= '0;
        end else if (accept && (evt_cnt_q != 16'hFFFF)) begin
            evt_cnt_q <= evt_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_qif_aer_arbiter.sv
// tb/tb_qif_aer_arbiter.sv - self-checking bench for qif_aer_arbiter
module tb_qif_aer_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    qif_aer_arbiter_if #(.N_CH(N), .TS_W(8), .AW(2)) bus ();

    qif_aer_arbiter #(.N_CH(N), .TS_W(8), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: per-neuron spike bookkeeping and one output slot
    int m_ts, m_valid, m_addr, m_time, m_last, m_cnt;
    int m_pend [N];
    int m_tlat [N];
    int m_ovf  [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ts = 0; m_valid = 0; m_addr = 0; m_time = 0; m_last = N - 1; m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_tlat[i] = 0; m_ovf[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] spk, input logic rdy, input logic clr);
        int free, grant, old_time;
        free  = (m_valid == 0) || rdy;
        grant = -1;
        if (m_valid != 0 && rdy && m_cnt < 65535) m_cnt++;
        if (free != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (grant < 0 && m_pend[(m_last + k) % N] != 0) grant = (m_last + k) % N;
            end
        end
        old_time = (grant >= 0) ? m_tlat[grant] : 0;
        for (int i = 0; i < N; i++) begin
            if (clr) m_ovf[i] = 0;
            if (spk[i]) begin
                if (m_pend[i] == 0 || i == grant) m_tlat[i] = m_ts;
                else m_ovf[i] = 1;
            end
            m_pend[i] = ((m_pend[i] != 0 && i != grant) || spk[i]) ? 1 : 0;
        end
        if (free != 0) begin
            if (grant >= 0) begin
                m_valid = 1; m_addr = grant; m_time = old_time; m_last = grant;
            end else begin
                m_valid = 0;
            end
        end
        m_ts = (m_ts + 1) % 256;
    endtask

    function automatic int ovf_vec();
        int v = 0;
        for (int i = 0; i < N; i++) v |= m_ovf[i] << i;
        return v;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_valid"}, 32'(bus.aer_valid), m_valid);
        check({tag, "_addr"},  32'(bus.aer_addr),  m_addr);
        check({tag, "_time"},  32'(bus.aer_time),  m_time);
        check({tag, "_ovf"},   32'(bus.overflow),  ovf_vec());
        check({tag, "_cnt"},   32'(bus.evt_cnt),   m_cnt);
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge
    task automatic step(input logic [N-1:0] spk, input logic rdy, input logic clr, input string tag);
        bus.spike_in  = spk;
        bus.aer_ready = rdy;
        bus.clear_ovf = clr;
        @(posedge clk);
        model_edge(spk, rdy, clr);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_rst_valid"}, 32'(bus.aer_valid), 0);
        check({tag, "_rst_addr"},  32'(bus.aer_addr),  0);
        check({tag, "_rst_time"},  32'(bus.aer_time),  0);
        check({tag, "_rst_ovf"},   32'(bus.overflow),  0);
        check({tag, "_rst_cnt"},   32'(bus.evt_cnt),   0);
    endtask

    // Assert reset between edges, check outputs before any edge, release at a negedge
    task automatic apply_reset(input string tag);
        #1 rst = 1'b1;
        #1 reset_values(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int t1, cap, cnt0, a0, t0;
        bus.spike_in = '0; bus.aer_ready = 1'b0; bus.clear_ovf = 1'b0;
        @(negedge clk);
        apply_reset("init");

        // Single spike at ts=5
        while (m_ts != 5) step(4'b0000, 1'b1, 1'b0, "idle");
        step(4'b0001, 1'b1, 1'b0, "s32a");
        check("s32_not_yet", 32'(bus.aer_valid), 0);
        step(4'b0000, 1'b1, 1'b0, "s32b");
        check("s32_valid", 32'(bus.aer_valid), 1);
        check("s32_addr",  32'(bus.aer_addr), 0);
        check("s32_time",  32'(bus.aer_time), 5);
        step(4'b0000, 1'b1, 1'b0, "s32c");
        check("s32_cnt", 32'(bus.evt_cnt), 1);

        // All four channels at once: round robin from channel 0, one timestamp
        apply_reset("pre33");
        step(4'b0000, 1'b1, 1'b0, "s33i");
        cap = m_ts;
        step(4'b1111, 1'b1, 1'b0, "s33s");
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 1'b1, 1'b0, "s33e");
            check("s33_valid", 32'(bus.aer_valid), 1);
            check("s33_addr",  32'(bus.aer_addr), k);
            check("s33_time",  32'(bus.aer_time), cap);
        end
        step(4'b0000, 1'b1, 1'b0, "s33z");
        check("s33_idle", 32'(bus.aer_valid), 0);

        // Overflow on channel 2 while the slot is blocked by channel 0
        step(4'b0001, 1'b0, 1'b0, "s34a");
        t1 = m_ts;
        step(4'b0100, 1'b0, 1'b0, "s34b");
        step(4'b0000, 1'b0, 1'b0, "s34c");
        step(4'b0000, 1'b0, 1'b0, "s34d");
        step(4'b0100, 1'b0, 1'b0, "s34e");
        check("s34_ovf", 32'(bus.overflow), 4'b0100);
        step(4'b0000, 1'b1, 1'b0, "s34f");
        check("s34_addr", 32'(bus.aer_addr), 2);
        check("s34_time", 32'(bus.aer_time), t1);
        step(4'b0000, 1'b1, 1'b0, "s34g");
        check("s34_single", 32'(bus.aer_valid), 0);
        step(4'b0000, 1'b1, 1'b1, "s34h");
        check("s34_clr", 32'(bus.overflow), 0);

        // Back-pressure hold for 10 cycles, then exactly one acceptance
        step(4'b0010, 1'b0, 1'b0, "s35a");
        step(4'b0000, 1'b0, 1'b0, "s35b");
        a0 = 32'(bus.aer_addr); t0 = 32'(bus.aer_time); cnt0 = m_cnt;
        for (int k = 0; k < 10; k++) begin
            step(4'b0000, 1'b0, 1'b0, "s35h");
            check("s35_addr_hold", 32'(bus.aer_addr), 1);
            check("s35_time_hold", 32'(bus.aer_time), m_time);
        end
        step(4'b0000, 1'b1, 1'b0, "s35r");
        step(4'b0000, 1'b0, 1'b0, "s35z");
        check("s35_cnt", 32'(bus.evt_cnt), cnt0 + 1);

        // Timestamp wrap: 255 on channel 1, then 0 on channel 3
        while (m_ts != 255) step(4'b0000, 1'b1, 1'b0, "wrapi");
        step(4'b0010, 1'b1, 1'b0, "s36a");
        step(4'b1000, 1'b1, 1'b0, "s36b");
        check("s36_addr1", 32'(bus.aer_addr), 1);
        check("s36_t255",  32'(bus.aer_time), 255);
        step(4'b0000, 1'b1, 1'b0, "s36c");
        check("s36_addr3", 32'(bus.aer_addr), 3);
        check("s36_t0",    32'(bus.aer_time), 0);
        step(4'b0000, 1'b1, 1'b0, "s36d");

        // Asynchronous reset with an event in flight and channels 1,3 pending
        step(4'b0001, 1'b0, 1'b0, "s37a");
        step(4'b1010, 1'b0, 1'b0, "s37b");
        step(4'b0000, 1'b0, 1'b0, "s37c");
        check("s37_busy", 32'(bus.aer_valid), 1);
        apply_reset("s37");
        for (int k = 0; k < 6; k++) begin
            step(4'b0000, 1'b1, 1'b0, "s37q");
            check("s37_quiet", 32'(bus.aer_valid), 0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/qif_aer_arbiter.md
QIF_AER_ARBITER -- requirements
Module: qif_aer_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of QIFNeuron spike_out lines arbitrated.
REQ-002 Parameter TS_W, default 8: timestamp width.
REQ-003 Parameter AW, default 2: address width; SHALL equal clog2(N_CH).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 spike_in  input  N_CH  one spike_out per neuron, sampled every rising edge.
REQ-007 aer_ready  input  1  downstream accepts the current event.
REQ-008 clear_ovf  input  1  synchronous clear of all overflow flags.
REQ-009 aer_valid  output  1  event present on aer_addr/aer_time.
REQ-010 aer_addr  output  AW  index of the spiking neuron.
REQ-011 aer_time  output  TS_W  timestamp latched at spike capture.
REQ-012 overflow  output  N_CH  sticky per-channel lost-spike flags.
REQ-013 evt_cnt  output  16  count of accepted events, saturating.

Function
REQ-014 Free-running counter ts (TS_W bits) SHALL increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-015 Per-channel pending bit: pending_next[i] = (pending[i] & ~issue[i]) | spike_in[i].
REQ-016 ts_lat[i] SHALL load the current ts when spike_in[i]=1 and (pending[i]=0 or issue[i]=1); otherwise it holds.
REQ-017 A spike on a pending, not-issued channel SHALL set overflow[i]; the spike is merged and ts_lat[i] is unchanged.
REQ-018 Output slot is free when aer_valid=0 or (aer_valid & aer_ready).
REQ-019 When the slot is free and any registered pending bit is 1, SHALL issue exactly one channel.
REQ-020 Issuing loads aer_addr=ch and aer_time=ts_lat[ch], sets aer_valid=1, clears pending[ch] and sets last_grant=ch.
REQ-021 Channel selection: round-robin, searching from last_grant+1 with wrap modulo N_CH; the first pending channel wins.
REQ-022 When the slot is free and nothing is pending, aer_valid SHALL go to 0.
REQ-023 While aer_valid=1 and aer_ready=0, aer_addr and aer_time SHALL hold stable.
REQ-024 Back-to-back issue SHALL occur when handshake and pending coincide, giving one event per cycle maximum.
REQ-025 Latency: spike sampled at edge t with the slot free gives aer_valid=1 after edge t+1. A spike captured in the same cycle is not eligible that cycle.
REQ-026 evt_cnt SHALL increment on each aer_valid & aer_ready cycle and saturate at 16'hFFFF.
REQ-027 clear_ovf=1 SHALL clear overflow at the next edge; a set in the same cycle wins for that bit.
REQ-028 Spikes on several channels in one cycle SHALL all be captured with the same ts_lat value.

Reset
REQ-029 While rst=1: ts=0, pending=0, ts_lat=0, aer_valid=0, aer_addr=0, aer_time=0, overflow=0, evt_cnt=0, last_grant=N_CH-1 (so channel 0 has first priority).
REQ-030 Reset asserted mid-handshake SHALL drop the event and pending spikes immediately and without waiting for a clock edge.
REQ-031 The first spike sampling SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-032 Reset release, aer_ready=1, spike_in=0001 for 1 cycle at ts=5 -> aer_valid=1 after the next edge with aer_addr=0, aer_time=5; evt_cnt=1 after acceptance.
REQ-033 spike_in=1111 for 1 cycle, aer_ready=1 -> four consecutive events with addr 0,1,2,3 and identical aer_time, then aer_valid=0.
REQ-034 aer_ready=0, spike_in[2] pulsed twice 3 cycles apart -> overflow=0100, one event addr 2 carrying the first timestamp; clear_ovf pulse -> overflow=0000.
REQ-035 aer_ready=0 with an event pending for 10 cycles -> aer_addr and aer_time constant; aer_ready=1 for 1 cycle -> exactly one acceptance counted.
REQ-036 Spike at ts=255, then a further spike on a second channel at ts=0 after wrap -> aer_time=255 then 0, in round-robin order.
REQ-037 rst asserted while aer_valid=1 and pending=1010 -> all outputs at reset values before the next edge; no events after release without new spikes.
